// File: rtl/microwave_timer_ctrl.sv
// Cooking-timer control: keypad MM:SS entry, counter load/tick generation, end-of-cook detect, magnetron gating.
// All outputs registered; flags derive from the next state so they line up with the state they belong to.
module microwave_timer_ctrl #(
  parameter int          TICK_DIV  = 100,
  parameter logic [15:0] QUICK_SEC = 16'h0030
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        key_valid,
  input  logic [3:0]  key_digit,
  input  logic        start,
  input  logic        stop_clear,
  input  logic        door_closed,
  input  logic        zero_su,
  input  logic        zero_st,
  input  logic        zero_mu,
  input  logic        zero_mt,
  output logic [15:0] load_data,
  output logic        loadn,
  output logic        count_en,
  output logic        magnetron_on,
  output logic        done,
  output logic [2:0]  state
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ENTRY = 3'd1,
    LOAD  = 3'd2,
    COOK  = 3'd3,
    PAUSE = 3'd4,
    CLEAR = 3'd5,
    DONE  = 3'd6
  } state_t;

  state_t        cur, nxt;
  logic [15:0]   data_nxt;
  logic [PW-1:0] pre, pre_nxt;
  logic          tick_nxt;
  logic          door_q;
  logic          all_zero, key_ok, door_fall;

  assign all_zero  = zero_su & zero_st & zero_mu & zero_mt;
  assign key_ok    = key_valid && (key_digit <= 4'd9);
  assign door_fall = door_q & ~door_closed;
  assign state     = cur;

  always_comb begin
    nxt      = cur;
    data_nxt = load_data;
    pre_nxt  = pre;
    tick_nxt = 1'b0;
    case (cur)
      IDLE: begin
        if (start && door_closed) begin
          data_nxt = QUICK_SEC;
          nxt      = LOAD;
        end else if (key_ok) begin
          data_nxt = {load_data[11:0], key_digit};
          nxt      = ENTRY;
        end
      end
      ENTRY: begin
        if (stop_clear) begin
          data_nxt = '0;
          nxt      = CLEAR;
        end else if (start && door_closed && (load_data != 16'h0000)) begin
          nxt = LOAD;
        end else if (key_ok) begin
          data_nxt = {load_data[11:0], key_digit};
        end
      end
      LOAD: begin
        pre_nxt = '0;
        nxt     = COOK;
      end
      COOK: begin
        // Pause and end-of-cook both swallow a coincident tick so a 00:00 count never wraps.
        if (!door_closed || stop_clear) begin
          nxt = PAUSE;
        end else if (all_zero) begin
          nxt = DONE;
        end else if (pre == PW'(TICK_DIV - 1)) begin
          pre_nxt  = '0;
          tick_nxt = 1'b1;
        end else begin
          pre_nxt = pre + PW'(1);
        end
      end
      PAUSE: begin
        if (stop_clear) begin
          data_nxt = '0;
          nxt      = CLEAR;
        end else if (start && door_closed) begin
          nxt = COOK;
        end
      end
      CLEAR: nxt = IDLE;
      DONE: begin
        if (stop_clear || door_fall) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cur          <= IDLE;
      load_data    <= '0;
      pre          <= '0;
      loadn        <= 1'b1;
      count_en     <= 1'b0;
      magnetron_on <= 1'b0;
      done         <= 1'b0;
      door_q       <= 1'b0;
    end else begin
      cur          <= nxt;
      load_data    <= data_nxt;
      pre          <= pre_nxt;
      loadn        <= !((nxt == LOAD) || (nxt == CLEAR));
      count_en     <= tick_nxt;
      magnetron_on <= (nxt == COOK);
      done         <= (nxt == DONE);
      door_q       <= door_closed;
    end
  end

endmodule

// File: tb/tb_microwave_timer_ctrl.sv
// Bench for microwave_timer_ctrl: directed scenarios plus a randomized run against a cycle reference model.
module tb_microwave_timer_ctrl;
  localparam int          TD    = 4;
  localparam logic [15:0] QUICK = 16'h0030;

  logic        clk = 1'b0;
  logic        rstn, key_valid, start, stop_clear, door_closed;
  logic [3:0]  key_digit;
  logic        zero_su, zero_st, zero_mu, zero_mt;
  logic [15:0] load_data;
  logic        loadn, count_en, magnetron_on, done;
  logic [2:0]  state;
  int          errors = 0;
  int          checks = 0;

  microwave_timer_ctrl #(.TICK_DIV(TD), .QUICK_SEC(QUICK)) dut (
    .clk(clk), .rstn(rstn), .key_valid(key_valid), .key_digit(key_digit),
    .start(start), .stop_clear(stop_clear), .door_closed(door_closed),
    .zero_su(zero_su), .zero_st(zero_st), .zero_mu(zero_mu), .zero_mt(zero_mt),
    .load_data(load_data), .loadn(loadn), .count_en(count_en),
    .magnetron_on(magnetron_on), .done(done), .state(state)
  );

  always #5 clk = ~clk;

  // External digit chain: sec-units mod 10, sec-tens mod 6, minutes mod 10 each.
  logic [3:0] e_su = '0, e_st = '0, e_mu = '0, e_mt = '0;
  assign zero_su = (e_su == 4'd0);
  assign zero_st = (e_st == 4'd0);
  assign zero_mu = (e_mu == 4'd0);
  assign zero_mt = (e_mt == 4'd0);

  always @(posedge clk) begin
    if (!loadn) begin
      {e_mt, e_mu, e_st, e_su} <= load_data;
    end else if (count_en) begin
      e_su <= (e_su == 4'd0) ? 4'd9 : e_su - 4'd1;
      if (e_su == 4'd0) begin
        e_st <= (e_st == 4'd0) ? 4'd5 : e_st - 4'd1;
        if (e_st == 4'd0) begin
          e_mu <= (e_mu == 4'd0) ? 4'd9 : e_mu - 4'd1;
          if (e_mu == 4'd0) e_mt <= (e_mt == 4'd0) ? 4'd9 : e_mt - 4'd1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press_key(input logic [3:0] d);
    key_valid = 1'b1; key_digit = d; tick(); key_valid = 1'b0;
  endtask

  task automatic press_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic press_stop();
    stop_clear = 1'b1; tick(); stop_clear = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", state); end
    checks++; if (load_data !== 16'h0000) begin errors++; $display("FAIL reset_data got=%h exp=0000", load_data); end
    checks++; if (loadn !== 1'b1) begin errors++; $display("FAIL reset_loadn got=%b exp=1", loadn); end
    checks++; if (count_en !== 1'b0) begin errors++; $display("FAIL reset_count_en got=%b exp=0", count_en); end
    checks++; if (magnetron_on !== 1'b0) begin errors++; $display("FAIL reset_mag got=%b exp=0", magnetron_on); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_keys_cook();
    int n, pulses, first, last, gap_bad, late;
    door_closed = 1'b1;
    press_key(4'd1); press_key(4'd3); press_key(4'd0);
    checks++; if (load_data !== 16'h0130) begin errors++; $display("FAIL entry_data got=%h exp=0130", load_data); end
    press_start();
    checks++; if (state !== 3'd2 || loadn !== 1'b0) begin errors++; $display("FAIL load_pulse state=%0d loadn=%b exp 2/0", state, loadn); end
    tick();
    checks++; if (state !== 3'd3 || loadn !== 1'b1 || magnetron_on !== 1'b1) begin
      errors++; $display("FAIL cook_entry state=%0d loadn=%b mag=%b exp 3/1/1", state, loadn, magnetron_on); end
    n = 0; pulses = 0; first = -1; last = 0; gap_bad = 0;
    while (state !== 3'd6 && n < 600) begin
      tick(); n++;
      if (count_en === 1'b1) begin
        if (first < 0) first = n; else if (n - last != TD) gap_bad++;
        last = n; pulses++;
      end
    end
    checks++; if (first != TD) begin errors++; $display("FAIL first_tick got=%0d exp=%0d", first, TD); end
    checks++; if (gap_bad != 0) begin errors++; $display("FAIL tick_spacing bad_gaps=%0d exp=0", gap_bad); end
    checks++; if (pulses != 90) begin errors++; $display("FAIL tick_count got=%0d exp=90", pulses); end
    checks++; if (n != 90 * TD + 2) begin errors++; $display("FAIL done_latency got=%0d exp=%0d", n, 90 * TD + 2); end
    checks++; if (done !== 1'b1 || magnetron_on !== 1'b0) begin errors++; $display("FAIL done_flags done=%b mag=%b exp 1/0", done, magnetron_on); end
    late = 0;
    for (int i = 0; i < 8; i++) begin tick(); if (count_en !== 1'b0) late++; end
    checks++; if (late != 0) begin errors++; $display("FAIL tick_after_done got=%0d exp=0", late); end
    press_stop();
    checks++; if (state !== 3'd0 || done !== 1'b0) begin errors++; $display("FAIL done_exit state=%0d done=%b exp 0/0", state, done); end
  endtask

  task automatic test_quick_start();
    press_start();
    checks++; if (state !== 3'd2 || load_data !== QUICK || loadn !== 1'b0) begin
      errors++; $display("FAIL quick_load state=%0d data=%h loadn=%b exp 2/%h/0", state, load_data, loadn, QUICK); end
    tick();
    checks++; if (state !== 3'd3) begin errors++; $display("FAIL quick_cook got=%0d exp=3", state); end
    press_stop(); press_stop(); tick();
    door_closed = 1'b0;
    press_start();
    checks++; if (state !== 3'd0 || loadn !== 1'b1) begin errors++; $display("FAIL door_open_start state=%0d loadn=%b exp 0/1", state, loadn); end
    door_closed = 1'b1;
  endtask

  task automatic test_pause_on_tick();
    press_key(4'd5); press_start(); tick();
    tick(); tick(); tick();
    door_closed = 1'b0;
    tick();
    checks++; if (state !== 3'd4 || count_en !== 1'b0 || magnetron_on !== 1'b0) begin
      errors++; $display("FAIL pause_on_tick state=%0d ce=%b mag=%b exp 4/0/0", state, count_en, magnetron_on); end
    tick(); tick();
    door_closed = 1'b1;
    tick();
    press_start();
    checks++; if (state !== 3'd3 || loadn !== 1'b1 || count_en !== 1'b0) begin
      errors++; $display("FAIL resume state=%0d loadn=%b ce=%b exp 3/1/0", state, loadn, count_en); end
    tick();
    checks++; if (count_en !== 1'b1) begin errors++; $display("FAIL resume_tick got=%b exp=1", count_en); end
    checks++; if ({e_mt, e_mu, e_st, e_su} !== 16'h0005) begin errors++; $display("FAIL no_reload got=%h exp=0005", {e_mt, e_mu, e_st, e_su}); end
  endtask

  task automatic test_stop_clear();
    press_stop();
    checks++; if (state !== 3'd4 || magnetron_on !== 1'b0) begin errors++; $display("FAIL stop_pause state=%0d mag=%b exp 4/0", state, magnetron_on); end
    press_stop();
    checks++; if (state !== 3'd5 || loadn !== 1'b0 || load_data !== 16'h0000) begin
      errors++; $display("FAIL clear state=%0d loadn=%b data=%h exp 5/0/0000", state, loadn, load_data); end
    tick();
    checks++; if (state !== 3'd0 || loadn !== 1'b1) begin errors++; $display("FAIL clear_idle state=%0d loadn=%b exp 0/1", state, loadn); end
  endtask

  task automatic test_entry_priority();
    press_key(4'd7); press_key(4'd12); press_key(4'd5);
    checks++; if (load_data !== 16'h0075 || state !== 3'd1) begin errors++; $display("FAIL bad_digit data=%h state=%0d exp 0075/1", load_data, state); end
    start = 1'b1; stop_clear = 1'b1; tick(); start = 1'b0; stop_clear = 1'b0;
    checks++; if (state !== 3'd5 || load_data !== 16'h0000) begin errors++; $display("FAIL clear_wins state=%0d data=%h exp 5/0000", state, load_data); end
    tick();
  endtask

  task automatic test_reset_midcook();
    int n;
    press_key(4'd2); press_start(); tick();
    n = 0;
    while (count_en !== 1'b1 && n < 20) begin tick(); n++; end
    checks++; if (count_en !== 1'b1) begin errors++; $display("FAIL wait_tick got=%b exp=1", count_en); end
    rstn = 1'b0;
    #1;
    checks++; if (state !== 3'd0 || count_en !== 1'b0 || magnetron_on !== 1'b0 || loadn !== 1'b1 || load_data !== 16'h0000 || done !== 1'b0) begin
      errors++; $display("FAIL async_reset state=%0d ce=%b mag=%b loadn=%b data=%h done=%b", state, count_en, magnetron_on, loadn, load_data, done); end
    #2; rstn = 1'b1;
    tick();
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL post_reset got=%0d exp=0", state); end
    press_key(4'd1); press_start(); tick();
    press_key(4'd9);
    checks++; if (load_data !== 16'h0001 || state !== 3'd3) begin errors++; $display("FAIL key_in_cook data=%h state=%0d exp 0001/3", load_data, state); end
    n = 0;
    while (state !== 3'd6 && n < 50) begin tick(); n++; end
    checks++; if (state !== 3'd6) begin errors++; $display("FAIL reach_done got=%0d exp=6", state); end
    press_key(4'd4); press_start();
    checks++; if (load_data !== 16'h0001 || state !== 3'd6) begin errors++; $display("FAIL key_in_done data=%h state=%0d exp 0001/6", load_data, state); end
    door_closed = 1'b0;
    tick();
    checks++; if (state !== 3'd0 || done !== 1'b0) begin errors++; $display("FAIL door_fall_exit state=%0d done=%b exp 0/0", state, done); end
    door_closed = 1'b1;
  endtask

  task automatic test_random();
    int ms, ns, mp, np;
    logic [15:0] md, nd;
    bit mce, nce, mdq, zero, kok;
    logic [3:0] digs [8] = '{4'd0, 4'd0, 4'd1, 4'd2, 4'd3, 4'd1, 4'd11, 4'd14};
    rstn = 1'b0; #2; rstn = 1'b1;
    ms = 0; md = '0; mp = 0; mce = 1'b0; mdq = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      key_valid   = ($urandom_range(0, 5) == 0);
      key_digit   = digs[$urandom_range(0, 7)];
      start       = ($urandom_range(0, 7) == 0);
      stop_clear  = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 47) == 0) door_closed = !door_closed;
      zero = zero_su && zero_st && zero_mu && zero_mt;
      kok  = key_valid && (key_digit < 10);
      ns = ms; nd = md; np = mp; nce = 1'b0;
      case (ms)
        0: if (start && door_closed) begin nd = QUICK; ns = 2; end
           else if (kok) begin nd = 16'(md * 16 + key_digit); ns = 1; end
        1: if (stop_clear) begin nd = 0; ns = 5; end
           else if (start && door_closed && md != 0) ns = 2;
           else if (kok) nd = 16'(md * 16 + key_digit);
        2: begin np = 0; ns = 3; end
        3: if (!door_closed || stop_clear) ns = 4;
           else if (zero) ns = 6;
           else begin np = (mp + 1) % TD; nce = (np == 0); end
        4: if (stop_clear) begin nd = 0; ns = 5; end
           else if (start && door_closed) ns = 3;
        5: ns = 0;
        6: if (stop_clear || (mdq && !door_closed)) ns = 0;
        default: ns = 0;
      endcase
      mdq = door_closed;
      tick();
      ms = ns; md = nd; mp = np; mce = nce;
      checks++;
      if (state !== 3'(ms) || load_data !== md || loadn !== !(ms == 2 || ms == 5) || count_en !== mce ||
          magnetron_on !== (ms == 3) || done !== (ms == 6)) begin
        errors++;
        $display("FAIL random cyc=%0d state=%0d/%0d data=%h/%h loadn=%b ce=%b/%b mag=%b done=%b", c, state, ms, load_data, md,
                 loadn, count_en, mce, magnetron_on, done);
      end
    end
  endtask

  initial begin
    rstn = 1'b0; key_valid = 1'b0; key_digit = '0; start = 1'b0; stop_clear = 1'b0; door_closed = 1'b1;
    test_reset();
    test_keys_cook();
    test_quick_start();
    test_pause_on_tick();
    test_stop_clear();
    test_entry_priority();
    test_reset_midcook();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/microwave_timer_ctrl.md
Name: microwave_timer_ctrl

Overview:
- Control end of the cooking-timer digit chain.
- Collects keypad digits into a 4-digit MM:SS preset and drives the data/loadn/enable inputs of the BCD/mod-6 down-counter digits.
- Generates the one-second count tick and reads back each digit's zero flag to detect end of cook.
- Gates the magnetron on door state and the start/stop keys.

Parameters:
- TICK_DIV, 100: clk cycles per count tick (one second). Minimum 2.
- QUICK_SEC, 16'h0030: BCD preset {min_t, min_u, sec_t, sec_u} loaded by start from IDLE.

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous reset, active-low
- key_valid  in  1  one-cycle strobe, key_digit valid
- key_digit  in  4  BCD key value
- start  in  1  one-cycle start/resume strobe
- stop_clear  in  1  one-cycle stop (first press) / clear (second press) strobe
- door_closed  in  1  level, 1 = door closed
- zero_su, zero_st, zero_mu, zero_mt  in  1 each  zero flags from the sec-units, sec-tens, min-units and min-tens counters
- load_data  out  16  {min_t, min_u, sec_t, sec_u} to the counter data inputs
- loadn  out  1  active-low parallel load to all digits
- count_en  out  1  one-cycle tick to the sec-units enable; cascade between digits is external
- magnetron_on  out  1  heater drive
- done  out  1  cook finished
- state  out  3  current FSM state, for debug and verification

Behaviour:
- Reset, asynchronous on rstn low:
  - state=IDLE; load_data=0; loadn=1; count_en=0; magnetron_on=0; done=0; prescaler=0.
  - Reset mid-cook returns to IDLE in the same instant, with no pulse on any output.
- State encoding: IDLE=0, ENTRY=1, LOAD=2, COOK=3, PAUSE=4, CLEAR=5, DONE=6.
- Key entry (IDLE or ENTRY only):
  - key_valid with key_digit<=9: load_data <= {load_data[11:0], key_digit}; go to ENTRY.
  - key_digit>9 is ignored.
  - No range clamp on the sec-tens digit.
  - key_valid in any other state is ignored.
- IDLE:
  - start with door_closed=1: load_data<=QUICK_SEC, go to LOAD.
  - start with door open: ignored.
- ENTRY:
  - stop_clear: go to CLEAR. This has priority over start.
  - start with door_closed=1 and load_data!=0: go to LOAD.
  - start with load_data==0: ignored.
- LOAD: loadn=0 for exactly one cycle with load_data stable; prescaler<=0; next state COOK.
- COOK:
  - magnetron_on=1 (registered, asserted the cycle the state is COOK).
  - Prescaler counts 0..TICK_DIV-1 and wraps. count_en=1 for the single cycle where prescaler==TICK_DIV-1.
  - First tick occurs TICK_DIV cycles after entering COOK.
  - Exit priority, highest first:
    1. door_closed=0 or stop_clear: go to PAUSE; count_en suppressed that cycle; prescaler held.
    2. All four zero inputs =1: go to DONE; count_en suppressed, so a 00:00 count never wraps.
  - Latency: the tick that takes the counters to 00:00 is followed one cycle later by all-zero, then DONE on the next edge.
- PAUSE:
  - magnetron_on=0; prescaler frozen.
  - stop_clear: go to CLEAR. This has priority.
  - start with door_closed=1: resume to COOK with the prescaler continuing from its held value; counters are not reloaded.
- CLEAR:
  - load_data<=0; loadn=0 for one cycle, driving data 0; next state IDLE.
- DONE:
  - done=1; magnetron_on=0.
  - stop_clear, or door_closed falling 1->0: go to IDLE, with done low from that cycle.
  - start and key_valid are ignored.
- Output timing: loadn and count_en are never low/high respectively outside LOAD/CLEAR and COOK; all outputs are registered.
- Door opening in IDLE, ENTRY, PAUSE or DONE (other than the DONE exit above) has no effect beyond blocking start.

Test Plan:
1. Keys 1,3,0 then start, door closed, TICK_DIV=4 -> load_data=16'h0130; one-cycle loadn low; magnetron_on=1; count_en every 4 cycles; after zero flags all high, state=DONE, done=1, magnetron_on=0, no further count_en.
2. Start in IDLE, door closed -> load_data=16'h0030, loadn pulse, COOK. Start in IDLE with door open -> state stays IDLE.
3. Door opens mid-COOK in the same cycle as a tick -> count_en stays 0, PAUSE, magnetron_on=0. Close door, start -> COOK, next tick after the remaining prescaler cycles, with no loadn pulse.
4. stop_clear in COOK -> PAUSE; second stop_clear -> CLEAR; loadn low with load_data=0; IDLE.
5. Keys 7, 12, 5 -> load_data=16'h0075 (12 ignored). start and stop_clear in the same cycle in ENTRY -> CLEAR wins.
6. rstn low during COOK with count_en high -> all outputs at reset values immediately; state=IDLE after release; key_valid during COOK/DONE leaves load_data unchanged.
